gcd_sched: RTL and testbench



---
 rtl/gcd_sched.sv | 147 ++++++++++++++
 tb/tb_gcd_sched.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_sched.sv
// Round-robin scheduler that shares one GCD core among NREQ requesters.
// Grants one request at a time, launches the core, and returns the result or a timeout error.
module gcd_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NREQ-1:0]              req_valid_i,
  input  logic [NREQ*W-1:0]            req_a_i,
  input  logic [NREQ*W-1:0]            req_b_i,
  output logic [NREQ-1:0]              req_ready_o,
  output logic                         rsp_valid_o,
  output logic [$clog2(NREQ)-1:0]      rsp_id_o,
  output logic [W-1:0]                 rsp_result_o,
  output logic                         rsp_err_o,
  output logic                         gcd_start_o,
  output logic [W-1:0]                 gcd_a_o,
  output logic [W-1:0]                 gcd_b_o,
  input  logic                         gcd_busy_i,
  input  logic                         gcd_valid_i,
  input  logic [W-1:0]                 gcd_result_i
);

  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [IdW-1:0]  last_q, last_d;
  logic [IdW-1:0]  id_q, id_d;
  logic [W-1:0]    op_a_q, op_a_d;
  logic [W-1:0]    op_b_q, op_b_d;
  logic [W-1:0]    result_q, result_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            w_grant_vld;
  logic [IdW-1:0]  w_grant_idx;
  logic [IdW-1:0]  w_cand;
  logic            w_unused;

  // The core's busy flag carries no information the scheduler needs.
  assign w_unused = gcd_busy_i;

  assign gcd_a_o = op_a_q;
  assign gcd_b_o = op_b_q;

  // Round-robin search starting just after the last requester served.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      w_cand = IdW'((32'(last_q) + i) % NREQ);
      if (!w_grant_vld && req_valid_i[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    id_d         = id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    result_d     = result_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    req_ready_o  = '0;
    gcd_start_o  = 1'b0;
    rsp_valid_o  = 1'b0;
    rsp_id_o     = '0;
    rsp_result_o = '0;
    rsp_err_o    = 1'b0;

    case (state_q)
      StIdle: begin
        // Ready is combinational, so hold it off while reset is still asserted.
        if (w_grant_vld && rst_ni) begin
          req_ready_o[w_grant_idx] = 1'b1;
          op_a_d  = req_a_i[32'(w_grant_idx) * W +: W];
          op_b_d  = req_b_i[32'(w_grant_idx) * W +: W];
          id_d    = w_grant_idx;
          state_d = StIssue;
        end
      end
      StIssue: begin
        gcd_start_o = 1'b1;
        cnt_d       = '0;
        state_d     = StWait;
      end
      StWait: begin
        if (gcd_valid_i) begin
          result_d = gcd_result_i;
          err_d    = 1'b0;
          state_d  = StResp;
        end else if (cnt_q == CntLast) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = StResp;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        rsp_valid_o  = 1'b1;
        rsp_id_o     = id_q;
        rsp_result_o = result_q;
        rsp_err_o    = err_q;
        last_d       = id_q;
        state_d      = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      last_q   <= IdW'(NREQ - 1);
      id_q     <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_gcd_sched.sv
// Self-checking bench for gcd_sched: behavioural GCD core, grant/response monitor,
// directed vector table, multi-cycle corner sequences and a randomized round-robin model.
`timescale 1ns/1ps
module tb_gcd_sched;
  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int TO   = 16;

  logic                 clk = 1'b0;
  logic                 rst_ni = 1'b0;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*W-1:0]    req_a, req_b;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic [1:0]           rsp_id;
  logic [W-1:0]         rsp_result;
  logic                 rsp_err;
  logic                 gcd_start;
  logic [W-1:0]         gcd_a, gcd_b;
  logic                 gcd_busy, gcd_valid;
  logic [W-1:0]         gcd_result;

  int                   core_lat  = 1;
  bit                   core_mute = 1'b0;
  int                   busy_cnt  = 0;
  logic                 core_valid = 1'b0;
  logic [W-1:0]         core_res = '0, core_a = '0, core_b = '0;
  logic                 spur = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int bad_ready = 0;
  int cyc = 0;

  typedef struct { int id; int cyc; } grant_t;
  typedef struct { int id; logic [W-1:0] res; logic err; int cyc; } rsp_t;
  typedef struct { int cyc; logic [W-1:0] a; logic [W-1:0] b; } start_t;
  typedef struct { int id; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] res; } vec_t;

  grant_t grant_q[$];
  rsp_t   rsp_q[$];
  start_t start_q[$];

  always #5 clk = ~clk;

  assign gcd_valid  = core_valid | spur;
  assign gcd_result = spur ? 32'hDEAD_BEEF : core_res;
  assign gcd_busy   = (busy_cnt != 0);

  gcd_sched #(.NREQ(NREQ), .W(W), .TIMEOUT(TO)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_ready_o  (req_ready),
    .rsp_valid_o  (rsp_valid),
    .rsp_id_o     (rsp_id),
    .rsp_result_o (rsp_result),
    .rsp_err_o    (rsp_err),
    .gcd_start_o  (gcd_start),
    .gcd_a_o      (gcd_a),
    .gcd_b_o      (gcd_b),
    .gcd_busy_i   (gcd_busy),
    .gcd_valid_i  (gcd_valid),
    .gcd_result_i (gcd_result)
  );

  function automatic logic [W-1:0] gcd_ref(logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Behavioural core: result strobe core_lat cycles after the start pulse.
  initial begin
    forever begin
      @(negedge clk);
      core_valid = 1'b0;
      if (!rst_ni) begin
        busy_cnt = 0;
      end else begin
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0 && !core_mute) begin
            core_valid = 1'b1;
            core_res   = gcd_ref(core_a, core_b);
          end
        end
        if (gcd_start) begin
          core_a   = gcd_a;
          core_b   = gcd_b;
          busy_cnt = core_lat;
        end
      end
    end
  end

  // Monitor: sampled mid-cycle, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!$onehot0(req_ready)) bad_ready++;
      if ((req_ready & ~req_valid) != '0) bad_ready++;
      if (rst_ni) begin
        for (int k = 0; k < NREQ; k++)
          if (req_ready[k] && req_valid[k]) grant_q.push_back('{id: k, cyc: cyc});
        if (rsp_valid)
          rsp_q.push_back('{id: int'(rsp_id), res: rsp_result, err: rsp_err, cyc: cyc});
        if (gcd_start) start_q.push_back('{cyc: cyc, a: gcd_a, b: gcd_b});
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_q();
    grant_q.delete();
    rsp_q.delete();
    start_q.delete();
  endtask

  task automatic set_req(input int k, input bit v, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[k]       = v;
    req_a[k*W +: W]    = a;
    req_b[k*W +: W]    = b;
  endtask

  task automatic drop_all();
    for (int k = 0; k < NREQ; k++) set_req(k, 1'b0, '0, '0);
  endtask

  task automatic wait_grants(input int n);
    int budget = 200;
    while (grant_q.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (grant_q.size() < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL grant_timeout: got %0d grants, expected %0d", grant_q.size(), n);
    end
  endtask

  task automatic wait_rsps(input int n);
    int budget = 200;
    while (rsp_q.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (rsp_q.size() < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL rsp_timeout: got %0d responses, expected %0d", rsp_q.size(), n);
    end
  endtask

  function automatic logic out_any();
    return |{req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, gcd_start, gcd_a, gcd_b};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    chk("reset_outputs_zero", 64'(out_any()), 64'(0));
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // Single transaction: request k, drop on grant, wait for the response.
  task automatic run_one(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    clear_q();
    set_req(k, 1'b1, a, b);
    wait_grants(1);
    drop_all();
    wait_rsps(1);
  endtask

  vec_t        vecs[6];
  logic [W-1:0] ea[NREQ], eb[NREQ];
  int          model_last;
  int          exp_id;
  int          mask;
  int          f;

  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    vecs[0] = '{id: 0, a: 48,  b: 18, res: 6};
    vecs[1] = '{id: 1, a: 0,   b: 7,  res: 7};
    vecs[2] = '{id: 2, a: 5,   b: 0,  res: 5};
    vecs[3] = '{id: 3, a: 12,  b: 8,  res: 4};
    vecs[4] = '{id: 1, a: 17,  b: 5,  res: 1};
    vecs[5] = '{id: 2, a: 100, b: 75, res: 25};

    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", 64'(out_any()), 64'(0));
    rst_ni = 1'b1;
    @(negedge clk);

    // Directed vector table, core latency 1 gives the minimum 3-cycle grant-to-response.
    core_lat = 1;
    for (int i = 0; i < 6; i++) begin
      run_one(vecs[i].id, vecs[i].a, vecs[i].b);
      if (grant_q.size() >= 1 && rsp_q.size() >= 1 && start_q.size() >= 1) begin
        chk($sformatf("vec%0d_grant_id", i), 64'(grant_q[0].id), 64'(vecs[i].id));
        chk($sformatf("vec%0d_start_a", i), 64'(start_q[0].a), 64'(vecs[i].a));
        chk($sformatf("vec%0d_start_b", i), 64'(start_q[0].b), 64'(vecs[i].b));
        chk($sformatf("vec%0d_rsp_id", i), 64'(rsp_q[0].id), 64'(vecs[i].id));
        chk($sformatf("vec%0d_result", i), 64'(rsp_q[0].res), 64'(vecs[i].res));
        chk($sformatf("vec%0d_err", i), 64'(rsp_q[0].err), 64'(0));
        chk($sformatf("vec%0d_start_cyc", i), 64'(start_q[0].cyc - grant_q[0].cyc), 64'(1));
        chk($sformatf("vec%0d_latency", i), 64'(rsp_q[0].cyc - grant_q[0].cyc), 64'(3));
      end
      chk($sformatf("vec%0d_one_start", i), 64'(start_q.size()), 64'(1));
    end

    // Contention from reset: all requesters held valid, grants must rotate 0,1,2,3,0.
    @(negedge clk);
    rst_ni = 1'b0;
    for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, 12, 8);
    @(negedge clk);
    chk("ready_held_in_reset", 64'(req_ready), 64'(0));
    clear_q();
    @(negedge clk);
    rst_ni = 1'b1;
    wait_grants(5);
    drop_all();
    wait_rsps(5);
    for (int i = 0; i < 5 && i < grant_q.size() && i < rsp_q.size(); i++) begin
      chk($sformatf("rr_grant%0d", i), 64'(grant_q[i].id), 64'(i % NREQ));
      chk($sformatf("rr_rsp_id%0d", i), 64'(rsp_q[i].id), 64'(i % NREQ));
      chk($sformatf("rr_result%0d", i), 64'(rsp_q[i].res), 64'(4));
    end

    // A request withdrawn before its grant is skipped.
    core_lat = 4;
    clear_q();
    set_req(0, 1'b1, 21, 14);
    wait_grants(1);
    drop_all();
    set_req(1, 1'b1, 10, 4);
    set_req(2, 1'b1, 9, 6);
    repeat (2) @(negedge clk);
    set_req(1, 1'b0, '0, '0);
    wait_grants(2);
    drop_all();
    wait_rsps(2);
    if (grant_q.size() >= 2 && rsp_q.size() >= 2) begin
      chk("withdraw_skip_grant", 64'(grant_q[1].id), 64'(2));
      chk("withdraw_first_result", 64'(rsp_q[0].res), 64'(7));
      chk("withdraw_second_result", 64'(rsp_q[1].res), 64'(3));
    end

    // Timeout: core silent, abort after TO full WAIT cycles.
    core_mute = 1'b1;
    run_one(3, 9, 6);
    core_mute = 1'b0;
    if (rsp_q.size() >= 1 && start_q.size() >= 1) begin
      chk("timeout_err", 64'(rsp_q[0].err), 64'(1));
      chk("timeout_result", 64'(rsp_q[0].res), 64'(0));
      chk("timeout_id", 64'(rsp_q[0].id), 64'(3));
      chk("timeout_latency", 64'(rsp_q[0].cyc - start_q[0].cyc), 64'(TO + 1));
    end

    // Valid in the last WAIT cycle beats the timeout.
    core_lat = TO;
    run_one(1, 35, 15);
    if (rsp_q.size() >= 1 && start_q.size() >= 1) begin
      chk("edge_valid_err", 64'(rsp_q[0].err), 64'(0));
      chk("edge_valid_result", 64'(rsp_q[0].res), 64'(5));
      chk("edge_valid_latency", 64'(rsp_q[0].cyc - start_q[0].cyc), 64'(TO + 1));
    end

    // Valid one cycle too late: timeout, and the late strobe in RESP is ignored.
    core_lat = TO + 1;
    run_one(2, 35, 15);
    repeat (5) @(negedge clk);
    chk("late_valid_rsp_count", 64'(rsp_q.size()), 64'(1));
    if (rsp_q.size() >= 1) chk("late_valid_err", 64'(rsp_q[0].err), 64'(1));

    // Normal service after a timeout.
    core_lat = 2;
    run_one(0, 48, 18);
    if (rsp_q.size() >= 1) begin
      chk("post_timeout_result", 64'(rsp_q[0].res), 64'(6));
      chk("post_timeout_err", 64'(rsp_q[0].err), 64'(0));
    end

    // Spurious core valid in IDLE and in ISSUE.
    core_lat = 3;
    clear_q();
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (3) @(negedge clk);
    chk("spur_idle_no_rsp", 64'(rsp_q.size()), 64'(0));
    set_req(0, 1'b1, 100, 75);
    wait_grants(1);
    drop_all();
    chk("spur_in_issue", 64'(gcd_start), 64'(1));
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    wait_rsps(1);
    repeat (5) @(negedge clk);
    chk("spur_rsp_count", 64'(rsp_q.size()), 64'(1));
    if (rsp_q.size() >= 1) begin
      chk("spur_result", 64'(rsp_q[0].res), 64'(25));
      chk("spur_err", 64'(rsp_q[0].err), 64'(0));
    end

    // Reset mid-WAIT: no response; last served was 0, so only reset makes 0 win over 1.
    core_mute = 1'b1;
    clear_q();
    set_req(3, 1'b1, 9, 6);
    wait_grants(1);
    drop_all();
    repeat (3) @(negedge clk);
    rst_ni = 1'b0;
    set_req(0, 1'b1, 27, 18);
    set_req(1, 1'b1, 40, 30);
    @(negedge clk);
    chk("midwait_reset_outputs_zero", 64'(out_any()), 64'(0));
    core_mute = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    wait_grants(2);
    drop_all();
    wait_rsps(1);
    if (grant_q.size() >= 2) chk("post_reset_grant", 64'(grant_q[1].id), 64'(0));
    if (rsp_q.size() >= 1) begin
      chk("post_reset_rsp_id", 64'(rsp_q[0].id), 64'(0));
      chk("post_reset_result", 64'(rsp_q[0].res), 64'(9));
    end

    // Randomized rounds against a round-robin / Euclid reference model.
    do_reset();
    @(negedge clk);
    model_last = NREQ - 1;
    for (int r = 0; r < 25; r++) begin
      mask     = $urandom_range(1, (1 << NREQ) - 1);
      core_lat = $urandom_range(1, 6);
      f        = $urandom_range(1, 20);
      clear_q();
      for (int k = 0; k < NREQ; k++) begin
        ea[k] = W'(f * $urandom_range(0, 200));
        eb[k] = W'(f * $urandom_range(0, 200));
        if (mask[k]) set_req(k, 1'b1, ea[k], eb[k]);
      end
      exp_id = -1;
      for (int j = 1; j <= NREQ; j++)
        if (exp_id < 0 && mask[(model_last + j) % NREQ]) exp_id = (model_last + j) % NREQ;
      wait_grants(1);
      drop_all();
      wait_rsps(1);
      if (grant_q.size() >= 1 && rsp_q.size() >= 1) begin
        chk($sformatf("rand%0d_grant", r), 64'(grant_q[0].id), 64'(exp_id));
        chk($sformatf("rand%0d_rsp_id", r), 64'(rsp_q[0].id), 64'(exp_id));
        chk($sformatf("rand%0d_result", r), 64'(rsp_q[0].res),
            64'(gcd_ref(ea[exp_id], eb[exp_id])));
        chk($sformatf("rand%0d_err", r), 64'(rsp_q[0].err), 64'(0));
      end
      model_last = exp_id;
    end

    chk("ready_onehot_and_qualified", 64'(bad_ready), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
